// File: rtl/seq_divider_64by32.sv
// Sequential 2N-by-N unsigned restoring divider: one quotient bit per clock.
// Divide-by-zero and quotient overflow are flagged one cycle after acceptance.
module seq_divider_64by32 #(
  parameter int size = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2*size-1:0] a,
  input  logic [size-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [size-1:0]   q,
  output logic [size-1:0]   r,
  output logic              div_by_zero,
  output logic              overflow
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam int         CW   = $clog2(size);

  logic [0:0]      state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_dbz_q, err_dbz_d;
  logic [size:0]   rem_q, rem_d;
  logic [size-1:0] shr_q, shr_d;
  logic [size-1:0] div_q, div_d;
  logic [size-1:0] q_q, q_d;
  logic [size-1:0] r_q, r_d;
  logic            dbz_q, dbz_d;
  logic            ovf_q, ovf_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [size:0]   rem_sh, rem_sub, rem_nx;
  logic            take;

  // Partial remainder stays below the divisor, so the shifted value fits in size+1 bits.
  assign rem_sh  = {rem_q[size-1:0], shr_q[size-1]};
  assign rem_sub = rem_sh - {1'b0, div_q};
  assign take    = (rem_sh >= {1'b0, div_q});
  assign rem_nx  = take ? rem_sub : rem_sh;

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_dbz_d = err_dbz_q;
    rem_d     = rem_q;
    shr_d     = shr_q;
    div_d     = div_q;
    q_d       = q_q;
    r_d       = r_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (busy_q) begin
          // Error result from the previous accept; shr_q still holds a[size-1:0].
          done_d = 1'b1;
          busy_d = 1'b0;
          q_d    = '1;
          r_d    = err_dbz_q ? shr_q : '0;
          dbz_d  = err_dbz_q;
          ovf_d  = !err_dbz_q;
        end else if (start) begin
          busy_d = 1'b1;
          div_d  = b;
          shr_d  = a[size-1:0];
          rem_d  = {1'b0, a[2*size-1:size]};
          cnt_d  = '0;
          if (b == '0)
            err_dbz_d = 1'b1;
          else if (a[2*size-1:size] >= b)
            err_dbz_d = 1'b0;
          else
            state_d = RUN;
        end
      end
      RUN: begin
        rem_d = rem_nx;
        shr_d = {shr_q[size-2:0], take};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(size-1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          q_d     = {shr_q[size-2:0], take};
          r_d     = rem_nx[size-1:0];
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_dbz_q <= 1'b0;
      rem_q     <= '0;
      shr_q     <= '0;
      div_q     <= '0;
      q_q       <= '0;
      r_q       <= '0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_dbz_q <= err_dbz_d;
      rem_q     <= rem_d;
      shr_q     <= shr_d;
      div_q     <= div_d;
      q_q       <= q_d;
      r_q       <= r_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign q           = q_q;
  assign r           = r_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
